// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: N masters share one slave, bus locked while the owner holds m_cyc.
// Includes an optional stalled-strobe timeout that answers the owner with a bus error.
module wb_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat,
    input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    output logic [DW-1:0]                 m_rdt,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [AW-1:0]                 s_adr,
    output logic [DW-1:0]                 s_dat,
    output logic [DW/8-1:0]               s_sel,
    output logic                          s_we,
    output logic                          s_cyc,
    output logic                          s_stb,
    input  logic [DW-1:0]                 s_rdt,
    input  logic                          s_ack,
    input  logic                          s_err,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [IW-1:0] winner;
    logic          found;
    logic [CW-1:0] cnt;
    logic          own_cyc;
    logic          own_stb;
    logic          active;
    logic          timeout_fire;

    // First requester scanning upward from last+1, wrapping.
    always_comb begin
        int unsigned cand;
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = (32'(last) + k) % NUM_MASTERS;
            if (!found && m_cyc[IW'(cand)]) begin
                found  = 1'b1;
                winner = IW'(cand);
            end
        end
    end

    // owner is held at 0 while idle, so the idle mux selects master 0.
    always_comb begin
        s_adr   = m_adr[AW-1:0];
        s_dat   = m_dat[DW-1:0];
        s_sel   = m_sel[DW/8-1:0];
        s_we    = m_we[0];
        own_cyc = m_cyc[0];
        own_stb = m_stb[0];
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (owner == IW'(i)) begin
                s_adr   = m_adr[i*AW +: AW];
                s_dat   = m_dat[i*DW +: DW];
                s_sel   = m_sel[i*(DW/8) +: DW/8];
                s_we    = m_we[i];
                own_cyc = m_cyc[i];
                own_stb = m_stb[i];
            end
        end
    end

    // Gating with wb_rst keeps the reset cycle itself silent towards masters and slave.
    assign active       = (state == BUSY) && !wb_rst;
    assign timeout_fire = (TIMEOUT != 0) && active && own_stb && (cnt == CW'(TIMEOUT))
                          && !s_ack && !s_err;

    assign s_cyc = active && own_cyc;
    assign s_stb = active && own_stb && !timeout_fire;
    assign m_rdt = s_rdt;
    assign m_ack = {NUM_MASTERS{active && s_ack}} & grant;
    assign m_err = {NUM_MASTERS{active && (s_err || timeout_fire)}} & grant;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            last  <= IW'(NUM_MASTERS - 1);
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (found) begin
                        state <= BUSY;
                        owner <= winner;
                        last  <= winner;
                        grant <= NUM_MASTERS'(1) << winner;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                        grant <= '0;
                        owner <= '0;
                        cnt   <= '0;
                    end else if (!own_stb || s_ack || s_err || timeout_fire) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
